// File: rtl/pcoeff_pkg.sv
// Shared record layout for pcoeff result records: field positions and the packer.
package pcoeff_pkg;
  localparam int RECORD_WIDTH        = 64;
  localparam int SEQ_WIDTH           = 2;
  localparam int DEFAULT_COUNT_WIDTH = 13;
  localparam int SUM_LSB             = 0;
  localparam int COUNT_LSB           = SUM_LSB + DEFAULT_COUNT_WIDTH + 35;
  localparam int SEQ_LSB             = COUNT_LSB + DEFAULT_COUNT_WIDTH;
  localparam int ECC_BIT             = SEQ_LSB + SEQ_WIDTH;

  typedef logic [RECORD_WIDTH-1:0] record_t;

  function automatic record_t fieldMask(input int width);
    if (width >= RECORD_WIDTH) return '1;
    return (record_t'(1) << width) - record_t'(1);
  endfunction

  // Fields stack from bit 0 upward (sum, count, seq, ecc); anything past bit 63 falls off.
  function automatic record_t packRecord(input logic ecc, input logic [SEQ_WIDTH-1:0] seq,
                                         input record_t count, input record_t sum,
                                         input int countWidth);
    int sumWidth;
    sumWidth = countWidth + 35;
    return (sum & fieldMask(sumWidth))
         | ((count & fieldMask(countWidth)) << sumWidth)
         | (record_t'(seq) << (sumWidth + countWidth))
         | (record_t'(ecc) << (sumWidth + countWidth + SEQ_WIDTH));
  endfunction
endpackage

// File: rtl/pcoeff_result_collector_if.sv
// Valid/ready record stream from the collector toward the host interface.
interface pcoeff_result_collector_if;
  import pcoeff_pkg::*;
  record_t outData;
  logic    outValid;
  logic    outReady;

  modport master (output outValid, output outData, input outReady);
  modport slave  (input outValid, input outData, output outReady);
endinterface

// File: rtl/result_fifo_sync.sv
// Synchronous show-ahead FIFO with registered head data, occupancy and almost-full.
module result_fifo_sync #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  output logic                     wrAccept,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic                     rdValid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     almostFull
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr, rdPtrNext;
  logic [CW-1:0]    countNext;
  logic             pop;

  assign rdValid   = (occupancy != '0);
  assign pop       = rdEn && rdValid;
  assign wrAccept  = wrEn && ((occupancy < CW'(DEPTH)) || pop);
  assign rdPtrNext = pop ? rdPtr + AW'(1) : rdPtr;

  always_comb begin
    countNext = occupancy;
    if (wrAccept && !pop)      countNext = occupancy + CW'(1);
    else if (pop && !wrAccept) countNext = occupancy - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      occupancy  <= '0;
      almostFull <= 1'b0;
      rdData     <= '0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + AW'(1);
      rdPtr      <= rdPtrNext;
      occupancy  <= countNext;
      almostFull <= (countNext >= CW'(AF_LEVEL));
      // Write pointer can only equal the next head when the new entry becomes the head.
      if (countNext != '0)
        rdData <= (wrAccept && (wrPtr == rdPtrNext)) ? wrData : mem[rdPtrNext];
    end
  end

  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr] <= wrData;
  end
endmodule

// File: rtl/pcoeff_result_collector.sv
// Captures finished batch results, tags them with a sequence number and streams them out.
module pcoeff_result_collector
  import pcoeff_pkg::*;
#(
  parameter int COUNT_WIDTH = 13,
  parameter int DEPTH       = 16,
  parameter int AF_MARGIN   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       resultsValid,
  input  logic [COUNT_WIDTH+34:0]    pcoeffSum,
  input  logic [COUNT_WIDTH-1:0]     pcoeffCount,
  input  logic                       eccStatus,
  pcoeff_result_collector_if.master  outBus,
  output logic                       almostFull,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflowError
);
  logic                 eccAcc;
  logic [SEQ_WIDTH-1:0] seq;
  logic                 wrAccept;
  record_t              record;

  assign record = packRecord(eccAcc | eccStatus, seq, RECORD_WIDTH'(pcoeffCount),
                             RECORD_WIDTH'(pcoeffSum), COUNT_WIDTH);

  // Seq advances even on a dropped record so the consumer sees the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      eccAcc        <= 1'b0;
      seq           <= '0;
      overflowError <= 1'b0;
    end else if (resultsValid) begin
      eccAcc <= 1'b0;
      seq    <= seq + SEQ_WIDTH'(1);
      if (!wrAccept) overflowError <= 1'b1;
    end else begin
      eccAcc <= eccAcc | eccStatus;
    end
  end

  result_fifo_sync #(
    .WIDTH   (RECORD_WIDTH),
    .DEPTH   (DEPTH),
    .AF_LEVEL(DEPTH - AF_MARGIN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wrEn      (resultsValid),
    .wrData    (record),
    .wrAccept  (wrAccept),
    .rdEn      (outBus.outReady),
    .rdData    (outBus.outData),
    .rdValid   (outBus.outValid),
    .occupancy (occupancy),
    .almostFull(almostFull)
  );
endmodule

// File: tb/tb_pcoeff_result_collector.sv
// Self-checking bench: table-driven streaming vectors plus hand sequences, scoreboard on pops.
module tb_pcoeff_result_collector;
  import pcoeff_pkg::*;

  typedef struct {
    logic [47:0] sum;
    logic [12:0] count;
    logic        ecc;
    logic [63:0] expRec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        resultsValid;
  logic        eccStatus;
  logic [47:0] pcoeffSum;
  logic [12:0] pcoeffCount;
  logic        almostFull;
  logic        overflowError;
  logic [4:0]  occupancy;

  pcoeff_result_collector_if bus ();

  pcoeff_result_collector #(.COUNT_WIDTH(13), .DEPTH(16), .AF_MARGIN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .resultsValid (resultsValid),
    .pcoeffSum    (pcoeffSum),
    .pcoeffCount  (pcoeffCount),
    .eccStatus    (eccStatus),
    .outBus       (bus.master),
    .almostFull   (almostFull),
    .occupancy    (occupancy),
    .overflowError(overflowError)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] expQ[$];
  logic [63:0] lastPopped = '0;
  logic [1:0]  expSeq = '0;
  vec_t        vecs[6];

  function automatic logic [63:0] mk(input logic e, input logic [1:0] s,
                                     input logic [12:0] c, input logic [47:0] sm);
    return {e, s, c, sm};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake compares the head record against the oldest expected one.
  always @(negedge clk) begin
    if (!rst && bus.outValid && bus.outReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h expected no record", bus.outData);
      end else begin
        check("pop_data", bus.outData, expQ.pop_front());
      end
      lastPopped = bus.outData;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [47:0] s, input logic [12:0] c, input logic e,
                        input bit accept, input logic [63:0] expRec);
    pcoeffSum    = s;
    pcoeffCount  = c;
    eccStatus    = e;
    resultsValid = 1'b1;
    if (accept) expQ.push_back(expRec);
    tick();
    resultsValid = 1'b0;
    eccStatus    = 1'b0;
    expSeq       = expSeq + 2'd1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.delete();
    expSeq = '0;
  endtask

  task automatic drain(input int maxCycles);
    int n;
    n = 0;
    bus.outReady = 1'b1;
    while (occupancy != 0 && n < maxCycles) begin
      tick();
      n++;
    end
    check("drain_done", 64'(occupancy), 64'd0);
    check("drain_queue_empty", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{48'h000000000024, 13'd3,      1'b0, 64'h0003_0000_0000_0024};
    vecs[1] = '{48'h123456789ABC, 13'h0AB,    1'b1, 64'hA0AB_1234_5678_9ABC};
    vecs[2] = '{48'hFFFFFFFFFFFF, 13'h1FFF,   1'b0, 64'h5FFF_FFFF_FFFF_FFFF};
    vecs[3] = '{48'h000000000000, 13'd0,      1'b0, 64'h6000_0000_0000_0000};
    vecs[4] = '{48'h000000000001, 13'd1,      1'b1, 64'h8001_0000_0000_0001};
    vecs[5] = '{48'h800000000000, 13'h1000,   1'b0, 64'h3000_8000_0000_0000};

    rst = 1'b1; resultsValid = 1'b0; eccStatus = 1'b0;
    pcoeffSum = '0; pcoeffCount = '0; bus.outReady = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_outValid", 64'(bus.outValid), 64'd0);
    check("reset_outData", bus.outData, 64'd0);
    check("reset_almostFull", 64'(almostFull), 64'd0);
    check("reset_occupancy", 64'(occupancy), 64'd0);
    check("reset_overflow", 64'(overflowError), 64'd0);

    // Single batch, one-cycle latency
    strobe(48'h24, 13'd3, 1'b0, 1'b1, 64'h0003_0000_0000_0024);
    check("single_valid", 64'(bus.outValid), 64'd1);
    check("single_data", bus.outData, 64'h0003_0000_0000_0024);
    check("single_occ", 64'(occupancy), 64'd1);
    bus.outReady = 1'b1;
    tick();
    check("single_popped_valid", 64'(bus.outValid), 64'd0);
    check("single_popped_occ", 64'(occupancy), 64'd0);

    // Table vectors streamed on consecutive cycles
    doReset();
    bus.outReady = 1'b1;
    for (int i = 0; i < 6; i++) strobe(vecs[i].sum, vecs[i].count, vecs[i].ecc, 1'b1, vecs[i].expRec);
    drain(20);

    // ECC seen three cycles before the strobe lands in that batch only
    doReset();
    bus.outReady = 1'b0;
    eccStatus = 1'b1;
    tick();
    eccStatus = 1'b0;
    tick(); tick();
    strobe(48'h10, 13'd4, 1'b0, 1'b1, mk(1'b1, expSeq, 13'd4, 48'h10));
    check("ecc_carry_bit", 64'(bus.outData[63]), 64'd1);
    strobe(48'h11, 13'd5, 1'b0, 1'b1, mk(1'b0, expSeq, 13'd5, 48'h11));
    drain(10);

    // Back-pressure fill, full-plus-pop, then overflow
    doReset();
    bus.outReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      strobe(48'(i * 7 + 1), 13'(i), 1'b0, 1'b1, mk(1'b0, expSeq, 13'(i), 48'(i * 7 + 1)));
      check("fill_occ", 64'(occupancy), 64'(i + 1));
      check("fill_almostFull", 64'(almostFull), (i + 1 >= 12) ? 64'd1 : 64'd0);
    end
    check("fill_head_stable", bus.outData, mk(1'b0, 2'd0, 13'd0, 48'd1));
    bus.outReady = 1'b1;
    strobe(48'hABC, 13'd99, 1'b0, 1'b1, mk(1'b0, expSeq, 13'd99, 48'hABC));
    bus.outReady = 1'b0;
    check("fullpop_occ", 64'(occupancy), 64'd16);
    check("fullpop_overflow", 64'(overflowError), 64'd0);
    strobe(48'hDEAD, 13'd7, 1'b0, 1'b0, 64'd0);
    check("drop_overflow", 64'(overflowError), 64'd1);
    check("drop_occ", 64'(occupancy), 64'd16);
    check("drop_almostFull", 64'(almostFull), 64'd1);
    drain(40);
    check("empty_valid", 64'(bus.outValid), 64'd0);
    check("empty_data_held", bus.outData, lastPopped);
    tick(); tick();
    check("empty_ready_noeffect", 64'(occupancy), 64'd0);
    check("overflow_sticky", 64'(overflowError), 64'd1);

    // Reset mid-stream discards buffered records and pending ECC
    bus.outReady = 1'b0;
    for (int i = 0; i < 5; i++) strobe(48'(i), 13'(i), 1'b0, 1'b1, mk(1'b0, expSeq, 13'(i), 48'(i)));
    check("pre_reset_occ", 64'(occupancy), 64'd5);
    eccStatus = 1'b1;
    tick();
    eccStatus = 1'b0;
    doReset();
    check("midreset_valid", 64'(bus.outValid), 64'd0);
    check("midreset_occ", 64'(occupancy), 64'd0);
    check("midreset_overflow", 64'(overflowError), 64'd0);
    check("midreset_almostFull", 64'(almostFull), 64'd0);
    check("midreset_data", bus.outData, 64'd0);
    strobe(48'h5, 13'd2, 1'b0, 1'b1, mk(1'b0, 2'd0, 13'd2, 48'h5));
    check("post_reset_seq", 64'(bus.outData[62:61]), 64'd0);
    check("post_reset_record", bus.outData, mk(1'b0, 2'd0, 13'd2, 48'h5));
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pcoeff_result_collector.md
# pcoeff_result_collector

Downstream of the aggregating pipeline. Captures each finished batch result (pcoeff sum, pcoeff count, ECC status) on the pipeline's one-cycle result strobe and tags it with a 2-bit sequence number. Buffers results in a synchronous FIFO and presents them as 64-bit records on a valid/ready stream toward the host interface. Provides an almost-full indication so the bot feeder can stop launching batches before results are lost.

## Interface
- COUNT_WIDTH, 13: pcoeff count width; sum width is COUNT_WIDTH+35.
- DEPTH, 16: FIFO entries, power of two, ≥4.
- AF_MARGIN, 4: almostFull asserts when occupancy ≥ DEPTH−AF_MARGIN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- resultsValid  in  1  one-cycle strobe: batch finished; sum/count valid this cycle
- pcoeffSum  in  COUNT_WIDTH+35  batch pcoeff sum
- pcoeffCount  in  COUNT_WIDTH  batch bot count
- eccStatus  in  1  per-cycle ECC/sanity error from pipeline
- outValid  out  1  record available
- outReady  in  1  consumer accepts record
- outData  out  64  record {ecc[63], seq[62:61], count[60:48], sum[47:0]} for default widths
- almostFull  out  1  occupancy ≥ DEPTH−AF_MARGIN
- occupancy  out  log2(DEPTH)+1  current entry count
- overflowError  out  1  sticky: a result was dropped

## Operation
- Batch ECC accumulator eccAcc: ORs eccStatus every cycle. The captured ecc bit is eccAcc | eccStatus of the strobe cycle. eccAcc clears on the strobe cycle; eccStatus arriving in that same cycle goes to the current batch only.
- Sequence counter seq (2 bit): increments on every resultsValid, including dropped ones, and wraps 3→0. A gap in seq at the consumer identifies a loss.
- Push: on resultsValid, write {ecc, seq, pcoeffCount, pcoeffSum} into the FIFO.
- Pop: on outValid && outReady.
- Full rule: push is accepted if occupancy < DEPTH, or if a pop happens in the same cycle. Otherwise the record is dropped, overflowError sets and stays set until rst, and occupancy is unchanged.
- Empty: outValid=0 and outData holds its last value. outReady while empty has no effect.
- Simultaneous push and pop at any occupancy leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- Packing: fields are zero-extended or truncated to the 64-bit layout per package constants. For COUNT_WIDTH≠13, fields pack from bit 0 upward (sum, count, seq, ecc) and unused MSBs are zero.
- outData is stable while outValid && !outReady.

## Timing
- Reset values: outValid=0, outData=0, almostFull=0, occupancy=0, overflowError=0, seq=0, eccAcc=0. Reset mid-stream discards all buffered records.
- Latency: a record pushed at edge N is visible at outValid/outData after edge N when the FIFO was empty (1 cycle). Otherwise it appears in order.
- occupancy and almostFull are registered and reflect the state after the last edge.
- resultsValid may assert on consecutive cycles; every cycle is a new batch.
- Throughput: 1 push and 1 pop per cycle.

## Structure
- Shared package pcoeff_pkg holds:
  - RECORD_WIDTH=64
  - bit positions ECC_BIT, SEQ_LSB, COUNT_LSB, SUM_LSB
  - SEQ_WIDTH=2
  - a function that packs a record
- Sub-module result_fifo_sync: parameterized width/depth, registered read data, show-ahead output, and an occupancy counter. The collector instantiates it with width 64.

## Test plan
- Single batch: strobe with sum=0x000000000024, count=3, eccStatus=0 → next cycle outValid=1, outData=0x0003_000000000024 (seq 0, ecc 0); outReady=1 → outValid=0.
- ECC carry: eccStatus=1 for one cycle three cycles before the strobe → record bit63=1. The following batch with no ECC has bit63=0 and seq=1.
- Back-pressure: outReady=0, 16 consecutive strobes → occupancy=16, almostFull=1 from occupancy 12. A 17th strobe → overflowError=1, occupancy stays 16. Then drain → seqs 0,1,2,3,0,… with the 17th (seq 0) absent.
- Full plus pop: occupancy=16, strobe with outReady=1 on the same cycle → push accepted, occupancy stays 16, overflowError stays 0.
- Reset mid-stream: 5 buffered records, rst for one cycle → outValid=0, occupancy=0, overflowError=0. The next strobe is tagged seq=0.
- Max values: count=8191, sum=2^48−1 → fields exact, no spill into seq/ecc bits.
